// File: rtl/tomasulo_pkg.sv
// Shared ROB parameters, opcode encodings and the entry record.
package tomasulo_pkg;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int FUNC_W = 4;

  typedef enum logic [FUNC_W-1:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    MUL = 4'b0010,
    DIV = 4'b0011
  } func_e;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Circular-buffer pointer with an extra wrap bit; clr takes priority over inc.
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W:0]   ptr
);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: allocate at tail, mark ready from the CDB, retire in order from head.
module rob_commit
  import tomasulo_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [FUNC_W-1:0] alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [FUNC_W-1:0] commit_func,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  rob_entry_t         entries [DEPTH];
  logic [DEPTH-1:0]   busy_vec;
  logic [DEPTH-1:0]   ready_vec;
  logic [TAG_W:0]     head;
  logic [TAG_W:0]     tail;
  logic [TAG_W-1:0]   head_idx;
  logic [TAG_W-1:0]   tail_idx;
  logic               do_alloc;
  logic               do_commit;
  logic               cdb_hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flags
      assign busy_vec[gi]  = entries[gi].busy;
      assign ready_vec[gi] = entries[gi].ready;
    end
  endgenerate

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];

  assign empty       = (head == tail);
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign count       = tail - head;
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;

  // Flush squashes every same-edge action, so it gates all three.
  assign do_alloc  = alloc_valid && !full && !flush;
  assign do_commit = !empty && busy_vec[head_idx] && ready_vec[head_idx] && !flush;
  assign cdb_hit   = cdb_valid && busy_vec[cdb_tag] && !flush;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk1  (clk1),
    .rst_n (rst_n),
    .inc   (do_commit),
    .clr   (flush),
    .ptr   (head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk1  (clk1),
    .rst_n (rst_n),
    .inc   (do_alloc),
    .clr   (flush),
    .ptr   (tail)
  );

  // Alloc and commit never target the same slot: that would need the ROB
  // to be both empty and full. Alloc beats a CDB aimed at the new slot.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].busy  <= 1'b0;
        entries[i].ready <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_alloc && (tail_idx == TAG_W'(i))) begin
          entries[i].busy  <= 1'b1;
          entries[i].ready <= 1'b0;
          entries[i].func  <= alloc_func;
          entries[i].rd    <= alloc_rd;
          entries[i].data  <= '0;
        end else if (cdb_hit && (cdb_tag == TAG_W'(i))) begin
          entries[i].ready <= 1'b1;
          entries[i].data  <= cdb_data;
        end
      end
      if (do_commit) begin
        entries[head_idx].busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
      commit_tag   <= '0;
      commit_func  <= '0;
    end else if (do_commit) begin
      commit_valid <= 1'b1;
      commit_rd    <= entries[head_idx].rd;
      commit_data  <= entries[head_idx].data;
      commit_tag   <= head_idx;
      commit_func  <= entries[head_idx].func;
    end else begin
      commit_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: reset, ordering, full, wrap, collisions, flush, async reset.
module tb_rob_commit;
  import tomasulo_pkg::*;

  logic              clk1;
  logic              rst_n;
  logic              alloc_valid;
  logic [FUNC_W-1:0] alloc_func;
  logic [REG_W-1:0]  alloc_rd;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic              commit_valid;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic [FUNC_W-1:0] commit_func;
  logic [TAG_W:0]    count;
  logic              empty;
  logic              full;

  int checks = 0;
  int errors = 0;

  rob_commit dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_func   (alloc_func),
    .alloc_rd     (alloc_rd),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .flush        (flush),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .commit_tag   (commit_tag),
    .commit_func  (commit_func),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Advance one rising edge and settle; inputs change only after this returns.
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b want=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b want=0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got=%0b want=0", commit_valid); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got=%0b want=1", alloc_ready); end
    checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_alloc_tag got=%0d want=0", alloc_tag); end
    $display("reset: empty=%0b full=%0b count=%0d", empty, full, count);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    alloc_valid = 1'b1; alloc_func = ADD; alloc_rd = 4'd3;
    tick();
    checks++; if (alloc_tag !== 3'd1) begin errors++; $display("FAIL io_alloc_tag got=%0d want=1", alloc_tag); end
    alloc_func = MUL; alloc_rd = 4'd5;
    tick();
    alloc_valid = 1'b0;
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL io_count got=%0d want=2", count); end
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h00AA;
    tick();
    cdb_tag = 3'd0; cdb_data = 16'h0011;
    tick();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL io_no_early_commit got=%0b want=0", commit_valid); end
    cdb_valid = 1'b0;
    tick();
    $display("commit: valid=%0b rd=%0d data=%h tag=%0d", commit_valid, commit_rd, commit_data, commit_tag);
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL io_c0_valid got=%0b want=1", commit_valid); end
    checks++; if (commit_rd !== 4'd3 || commit_data !== 16'h0011 || commit_tag !== 3'd0 || commit_func !== ADD)
      begin errors++; $display("FAIL io_c0_fields got=rd%0d/%h/t%0d/f%0d want=rd3/0011/t0/f0", commit_rd, commit_data, commit_tag, commit_func); end
    tick();
    $display("commit: valid=%0b rd=%0d data=%h tag=%0d", commit_valid, commit_rd, commit_data, commit_tag);
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL io_c1_valid got=%0b want=1", commit_valid); end
    checks++; if (commit_rd !== 4'd5 || commit_data !== 16'h00AA || commit_tag !== 3'd1 || commit_func !== MUL)
      begin errors++; $display("FAIL io_c1_fields got=rd%0d/%h/t%0d/f%0d want=rd5/00aa/t1/f2", commit_rd, commit_data, commit_tag, commit_func); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL io_empty got=%0b want=1", empty); end
    tick();
    checks++; if (commit_valid !== 1'b0 || commit_rd !== 4'd5 || commit_data !== 16'h00AA)
      begin errors++; $display("FAIL io_hold got=v%0b/rd%0d/%h want=v0/rd5/00aa", commit_valid, commit_rd, commit_data); end
  endtask

  task automatic test_full();
    do_flush();
    alloc_valid = 1'b1; alloc_func = SUB;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_rd = 4'(i);
      checks++; if (alloc_tag !== 3'(i)) begin errors++; $display("FAIL full_tag%0d got=%0d want=%0d", i, alloc_tag, i); end
      tick();
    end
    $display("full: full=%0b count=%0d alloc_ready=%0b", full, count, alloc_ready);
    checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 4'd8)
      begin errors++; $display("FAIL full_flags got=f%0b/r%0b/c%0d want=f1/r0/c8", full, alloc_ready, count); end
    tick();
    alloc_valid = 1'b0;
    checks++; if (count !== 4'd8 || alloc_tag !== 3'd0)
      begin errors++; $display("FAIL full_drop got=c%0d/t%0d want=c8/t0", count, alloc_tag); end
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h1234;
    tick();
    cdb_valid = 1'b0;
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || commit_data !== 16'h1234)
      begin errors++; $display("FAIL full_commit got=v%0b/t%0d/%h want=v1/t0/1234", commit_valid, commit_tag, commit_data); end
    checks++; if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0)
      begin errors++; $display("FAIL full_reopen got=c%0d/r%0b/t%0d want=c7/r1/t0", count, alloc_ready, alloc_tag); end
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    checks++; if (count !== 4'd8 || full !== 1'b1)
      begin errors++; $display("FAIL full_realloc got=c%0d/f%0b want=c8/f1", count, full); end
    do_flush();
  endtask

  task automatic test_wrap();
    for (int j = 0; j < 20; j++) begin
      alloc_valid = 1'b1; alloc_func = DIV; alloc_rd = 4'(j);
      tick();
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 3'(j % 8); cdb_data = 16'h0100 + 16'(j);
      tick();
      cdb_valid = 1'b0;
      tick();
      $display("wrap %0d: valid=%0b tag=%0d data=%h", j, commit_valid, commit_tag, commit_data);
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 3'(j % 8) || commit_data !== 16'h0100 + 16'(j) || commit_rd !== 4'(j))
        begin errors++; $display("FAIL wrap%0d got=v%0b/t%0d/%h/rd%0d want=v1/t%0d/%h/rd%0d",
          j, commit_valid, commit_tag, commit_data, commit_rd, j % 8, 16'h0100 + 16'(j), j % 16); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%0b want=1", empty); end
  endtask

  task automatic test_simultaneous();
    do_flush();
    alloc_valid = 1'b1; alloc_func = ADD; alloc_rd = 4'd1;
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h0AAA;
    tick();
    // Commit of tag0, alloc of tag1, and a CDB aimed at tag1 all on one edge.
    alloc_valid = 1'b1; alloc_rd = 4'd2;
    cdb_tag = 3'd1; cdb_data = 16'hBEEF;
    tick();
    alloc_valid = 1'b0; cdb_valid = 1'b0;
    $display("sim: valid=%0b tag=%0d count=%0d", commit_valid, commit_tag, count);
    checks++; if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || count !== 4'd1)
      begin errors++; $display("FAIL sim_alloc_commit got=v%0b/t%0d/c%0d want=v1/t0/c1", commit_valid, commit_tag, count); end
    tick();
    tick();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL sim_alloc_wins got=%0b want=0", commit_valid); end
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h5555;
    tick();
    cdb_valid = 1'b0;
    tick();
    checks++; if (commit_valid !== 1'b0 || count !== 4'd1)
      begin errors++; $display("FAIL sim_nonbusy got=v%0b/c%0d want=v0/c1", commit_valid, count); end
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h0077;
    tick();
    cdb_valid = 1'b0;
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_tag !== 3'd1 || commit_data !== 16'h0077 || commit_rd !== 4'd2)
      begin errors++; $display("FAIL sim_late_commit got=v%0b/t%0d/%h/rd%0d want=v1/t1/0077/rd2", commit_valid, commit_tag, commit_data, commit_rd); end
  endtask

  task automatic test_flush();
    do_flush();
    alloc_valid = 1'b1; alloc_func = SUB;
    for (int i = 0; i < 5; i++) begin
      alloc_rd = 4'(i + 8);
      tick();
    end
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h3333;
    tick();
    cdb_tag = 3'd0; cdb_data = 16'h0F0F;
    tick();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got=%0d want=5", count); end
    // Head is ready, so this edge would commit without the flush.
    flush = 1'b1; alloc_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h4444;
    tick();
    flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
    $display("flush: count=%0d empty=%0b valid=%0b", count, empty, commit_valid);
    checks++; if (count !== 4'd0 || empty !== 1'b1 || commit_valid !== 1'b0)
      begin errors++; $display("FAIL flush_state got=c%0d/e%0b/v%0b want=c0/e1/v0", count, empty, commit_valid); end
    checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL flush_tail got=%0d want=0", alloc_tag); end
    tick();
    checks++; if (commit_valid !== 1'b0 || count !== 4'd0)
      begin errors++; $display("FAIL flush_after got=v%0b/c%0d want=v0/c0", commit_valid, count); end
  endtask

  task automatic test_async_reset();
    do_flush();
    alloc_valid = 1'b1; alloc_func = MUL; alloc_rd = 4'd9;
    tick();
    alloc_rd = 4'd10;
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h4242;
    tick();
    alloc_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_data !== 16'h4242 || count !== 4'd1)
      begin errors++; $display("FAIL arst_pre got=v%0b/%h/c%0d want=v1/4242/c1", commit_valid, commit_data, count); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("arst: valid=%0b count=%0d empty=%0b", commit_valid, count, empty);
    checks++; if (commit_valid !== 1'b0 || commit_data !== 16'h0000 || commit_rd !== 4'd0)
      begin errors++; $display("FAIL arst_commit got=v%0b/%h/rd%0d want=v0/0000/rd0", commit_valid, commit_data, commit_rd); end
    checks++; if (count !== 4'd0 || empty !== 1'b1 || alloc_tag !== 3'd0)
      begin errors++; $display("FAIL arst_ptrs got=c%0d/e%0b/t%0d want=c0/e1/t0", count, empty, alloc_tag); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (commit_valid !== 1'b0 || count !== 4'd0)
      begin errors++; $display("FAIL arst_after got=v%0b/c%0d want=v0/c0", commit_valid, count); end
  endtask

  initial begin
    alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    flush = 1'b0;
    test_reset();
    test_in_order();
    test_full();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
